tile_spawner: RTL and testbench
===============================

Name: tile_spawner

Overview:
- Consumes the 4-bit pseudo-random stream from the xorshift unit.
- On each move-complete request, places one new tile (exponent 1 = "2", exponent 2 = "4") in a random empty cell of the 4x4 board.
- Sits between the random unit and the board register file. Its write port drives the board; its done pulse hands control back to the game FSM.

Parameters:
- MAX_TRIES, 8: random index attempts before falling back to a linear scan.
- FOUR_THRESH, 2: a tile is "4" (exponent 2) when the sampled rand < FOUR_THRESH (2/16); otherwise it is "2".

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req  in  1  spawn request pulse. Accepted only in IDLE.
- board  in  64  16 cells x 4-bit exponent. Cell i is board[4i+3:4i]; 0 means empty.
- rand  in  4  random value from the xorshift unit. Changes every cycle.
- busy  out  1  high from the cycle after acceptance until done, inclusive.
- done  out  1  one-cycle completion pulse.
- full  out  1  valid with done: no empty cell existed, so nothing was written.
- spawn_we  out  1  one-cycle board write enable, coincident with done.
- spawn_idx  out  4  target cell index, valid while spawn_we=1.
- spawn_exp  out  4  exponent to write (1 or 2), valid while spawn_we=1.

Behaviour:
- Reset (rst=0 at posedge):
  - State goes to IDLE.
  - busy, done, full, spawn_we = 0; spawn_idx, spawn_exp, try_cnt, scan_ptr = 0.
  - Reset mid-operation aborts with no write.
- States: IDLE, PICK, SCAN, VALUE, DONE.
- IDLE:
  - req=1 latches board into snap and computes the empty mask from snap.
  - Mask nonzero: go to PICK with try_cnt=0.
  - Mask zero: go to DONE with no_space flag set.
  - req=0: stay in IDLE.
- PICK (one attempt per cycle, using the current rand):
  - mask[rand]=1: capture spawn_idx=rand, go to VALUE.
  - Else if try_cnt==MAX_TRIES-1: scan_ptr=rand+1 (mod 16), go to SCAN.
  - Else: try_cnt+1 and stay in PICK.
- SCAN (one cell per cycle):
  - mask[scan_ptr]=1: capture spawn_idx=scan_ptr, go to VALUE.
  - Else: scan_ptr+1, wrapping 15 to 0.
  - Always terminates within 16 cycles because the mask is nonzero.
- VALUE: spawn_exp = (rand < FOUR_THRESH) ? 2 : 1, then go to DONE.
  - This rand sample is a different cycle from the index sample.
- DONE (one cycle), then return to IDLE:
  - done=1.
  - Normal path: spawn_we=1, full=0.
  - No-space path: spawn_we=0, full=1.
- Outputs are registered and decoded from state. busy=1 in PICK, SCAN, VALUE and DONE.
- req while not in IDLE is ignored and not queued. req in the IDLE cycle that immediately follows DONE is accepted.
- Board changes after acceptance are ignored; only snap is used.
- Latency from req at cycle T:
  - best case: done at T+3.
  - full board: done at T+1.
  - worst case: done at T+1+MAX_TRIES+16+1.
- spawn_idx and spawn_exp hold their last values outside DONE. Consumers use them only when spawn_we=1.

Decomposition:
- Package game_pkg:
  - N_CELLS=16, CELL_W=4, EMPTY_EXP=4'd0.
  - Spawner state enum (IDLE, PICK, SCAN, VALUE, DONE).
  - Exponent constants EXP_2=4'd1, EXP_4=4'd2.
- Sub-module tile_empty_mask: combinational, 64-bit board in, 16-bit mask out (bit i = cell i == 0). It will be reused by the game-over detector.

Test Plan:
- Reset check: hold rst=0 for 3 cycles while driving req=1 -> busy=done=spawn_we=full=0. Release rst -> request accepted next IDLE cycle.
- Direct hit: board all zeros; rand=5 at T+1 and rand=9 at T+2 -> done and spawn_we at T+3, spawn_idx=5, spawn_exp=1.
- "4" selection: board empty; rand=3 at T+1 and rand=1 at T+2 -> spawn_idx=3, spawn_exp=2, done at T+3.
- Scan fallback: only cell 2 empty; rand held at 7 for all PICK cycles -> 8 PICK cycles, then SCAN 8..15,0,1,2 -> spawn_idx=2, done exactly at T+1+8+11+1.
- Full board: all cells = 4'd3 -> at T+1 done=1, full=1, spawn_we=0, busy=1 for that one cycle.
- Robustness:
  - req pulses while busy are ignored.
  - Board altered mid-operation so a previously empty cell is filled does not change the result from snap.
  - rst=0 in SCAN -> IDLE with no spawn_we pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared board geometry, tile exponents and spawner state encodings for the game datapath.
package game_pkg;

    localparam int unsigned N_CELLS   = 16;
    localparam int unsigned CELL_W    = 4;
    localparam logic [3:0]  EMPTY_EXP = 4'd0;

    localparam logic [3:0]  EXP_2     = 4'd1;
    localparam logic [3:0]  EXP_4     = 4'd2;

    typedef logic [2:0] spawn_state_t;

    localparam spawn_state_t S_IDLE  = 3'd0;
    localparam spawn_state_t S_PICK  = 3'd1;
    localparam spawn_state_t S_SCAN  = 3'd2;
    localparam spawn_state_t S_VALUE = 3'd3;
    localparam spawn_state_t S_DONE  = 3'd4;

endpackage

// File: rtl/tile_empty_mask.sv
// Flags every empty cell of the packed 4x4 board; shared with the game-over detector.
module tile_empty_mask
    import game_pkg::*;
(
    input  logic [N_CELLS*CELL_W-1:0] board,
    output logic [N_CELLS-1:0]        mask
);

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            mask[i] = (board[i*CELL_W +: CELL_W] == EMPTY_EXP);
        end
    end

endmodule

// File: rtl/tile_spawner.sv
// Places one random "2" or "4" tile in an empty board cell per request, with a linear-scan fallback.
module tile_spawner
    import game_pkg::*;
#(
    parameter int unsigned MAX_TRIES   = 8,
    parameter int unsigned FOUR_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic [N_CELLS*CELL_W-1:0] board,
    input  logic [3:0]                rnd,
    output logic                      busy,
    output logic                      done,
    output logic                      full,
    output logic                      spawn_we,
    output logic [3:0]                spawn_idx,
    output logic [3:0]                spawn_exp
);

    localparam int unsigned       TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0]  LAST_TRY = TRY_W'(MAX_TRIES - 1);

    spawn_state_t        state, state_next;
    logic [N_CELLS-1:0]  board_mask;
    logic [N_CELLS-1:0]  snap_mask;
    logic [TRY_W-1:0]    try_cnt;
    logic [3:0]          scan_ptr;
    logic                no_space, no_space_next;

    tile_empty_mask u_mask (
        .board (board),
        .mask  (board_mask)
    );

    always_comb begin
        state_next    = state;
        no_space_next = no_space;
        case (state)
            S_IDLE: begin
                if (req) begin
                    no_space_next = ~|board_mask;
                    state_next    = (|board_mask) ? S_PICK : S_DONE;
                end
            end
            S_PICK: begin
                if (snap_mask[rnd])            state_next = S_VALUE;
                else if (try_cnt == LAST_TRY)  state_next = S_SCAN;
            end
            S_SCAN:  if (snap_mask[scan_ptr]) state_next = S_VALUE;
            S_VALUE: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Only the empty mask of the accepted board is kept; later board edits are invisible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            snap_mask <= '0;
            try_cnt   <= '0;
            scan_ptr  <= '0;
            no_space  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            full      <= 1'b0;
            spawn_we  <= 1'b0;
            spawn_idx <= '0;
            spawn_exp <= '0;
        end else begin
            state    <= state_next;
            no_space <= no_space_next;
            busy     <= (state_next != S_IDLE);
            done     <= (state_next == S_DONE);
            spawn_we <= (state_next == S_DONE) && !no_space_next;
            full     <= (state_next == S_DONE) && no_space_next;

            case (state)
                S_IDLE: begin
                    if (req) begin
                        snap_mask <= board_mask;
                        try_cnt   <= '0;
                    end
                end
                S_PICK: begin
                    if (snap_mask[rnd])           spawn_idx <= rnd;
                    else if (try_cnt == LAST_TRY) scan_ptr  <= rnd + 4'd1;
                    else                          try_cnt   <= try_cnt + 1'b1;
                end
                S_SCAN: begin
                    if (snap_mask[scan_ptr]) spawn_idx <= scan_ptr;
                    else                     scan_ptr  <= scan_ptr + 4'd1;
                end
                S_VALUE: spawn_exp <= (32'(rnd) < FOUR_THRESH) ? EXP_4 : EXP_2;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_spawner.sv
// Directed bench for tile_spawner: inputs change and outputs are sampled on the falling edge.
module tb_tile_spawner;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [63:0] board;
    logic [3:0]  rnd;
    logic        busy, done, full, spawn_we;
    logic [3:0]  spawn_idx, spawn_exp;

    int n_checks = 0;
    int n_fail   = 0;
    int early    = 0;
    int we_seen  = 0;

    tile_spawner #(
        .MAX_TRIES   (8),
        .FOUR_THRESH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .board     (board),
        .rnd       (rnd),
        .busy      (busy),
        .done      (done),
        .full      (full),
        .spawn_we  (spawn_we),
        .spawn_idx (spawn_idx),
        .spawn_exp (spawn_exp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b0;
        req   = 1'b1;
        board = '0;
        rnd   = 4'd0;

        // reset held with req asserted
        repeat (3) begin
            cyc();
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_we",   32'(spawn_we), 32'd0);
            chk("rst_full", 32'(full), 32'd0);
        end

        // release: request accepted on the first IDLE edge
        rst = 1'b1;
        cyc();
        chk("post_rst_busy", 32'(busy), 32'd1);
        req = 1'b0; rnd = 4'd0;
        cyc();
        rnd = 4'd15;
        cyc();
        chk("post_rst_done", 32'(done), 32'd1);
        chk("post_rst_idx",  32'(spawn_idx), 32'd0);
        chk("post_rst_exp",  32'(spawn_exp), 32'd1);
        cyc();
        chk("post_rst_idle", 32'(busy), 32'd0);

        // direct hit
        req = 1'b1; board = '0; rnd = 4'd0;
        cyc();
        req = 1'b0; rnd = 4'd5;
        chk("hit_busy_t1", 32'(busy), 32'd1);
        chk("hit_done_t1", 32'(done), 32'd0);
        cyc();
        rnd = 4'd9;
        chk("hit_done_t2", 32'(done), 32'd0);
        cyc();
        chk("hit_done_t3", 32'(done), 32'd1);
        chk("hit_we_t3",   32'(spawn_we), 32'd1);
        chk("hit_full_t3", 32'(full), 32'd0);
        chk("hit_idx",     32'(spawn_idx), 32'd5);
        chk("hit_exp",     32'(spawn_exp), 32'd1);
        cyc();
        chk("hit_done_t4", 32'(done), 32'd0);
        chk("hit_busy_t4", 32'(busy), 32'd0);
        chk("hit_idx_hold", 32'(spawn_idx), 32'd5);

        // "4" selection, with cell 3 filled after acceptance
        req = 1'b1; board = '0;
        cyc();
        req = 1'b0; rnd = 4'd3; board = 64'h0000_0000_0000_3000;
        cyc();
        rnd = 4'd1;
        cyc();
        chk("four_done", 32'(done), 32'd1);
        chk("four_we",   32'(spawn_we), 32'd1);
        chk("four_idx",  32'(spawn_idx), 32'd3);
        chk("four_exp",  32'(spawn_exp), 32'd2);
        cyc();
        chk("four_idle", 32'(busy), 32'd0);

        // full board, then a request held across DONE into IDLE
        board = 64'h3333_3333_3333_3333; req = 1'b1;
        cyc();
        chk("full_done", 32'(done), 32'd1);
        chk("full_full", 32'(full), 32'd1);
        chk("full_we",   32'(spawn_we), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        cyc();
        chk("full_idle_busy", 32'(busy), 32'd0);
        chk("full_idle_done", 32'(done), 32'd0);
        cyc();
        req = 1'b0;
        chk("full2_done", 32'(done), 32'd1);
        chk("full2_full", 32'(full), 32'd1);
        chk("full2_we",   32'(spawn_we), 32'd0);
        cyc();
        chk("full2_idle", 32'(busy), 32'd0);
        chk("full2_full_clr", 32'(full), 32'd0);

        // scan fallback: only cell 2 empty, rnd stuck at 7, stray req while busy
        board = 64'h1111_1111_1111_1011; rnd = 4'd7; req = 1'b1;
        cyc();
        req = 1'b0;
        early = 0;
        if (done) early++;
        for (int k = 2; k <= 20; k++) begin
            cyc();
            req = (k == 5);
            if (done) early++;
        end
        chk("scan_no_early_done", 32'(early), 32'd0);
        chk("scan_busy_t20", 32'(busy), 32'd1);
        cyc();
        chk("scan_done", 32'(done), 32'd1);
        chk("scan_we",   32'(spawn_we), 32'd1);
        chk("scan_idx",  32'(spawn_idx), 32'd2);
        chk("scan_exp",  32'(spawn_exp), 32'd1);
        cyc();
        chk("scan_idle_t22", 32'(busy), 32'd0);
        cyc();
        chk("scan_not_queued", 32'(busy), 32'd0);

        // reset asserted while scanning
        board = 64'h1111_1111_1111_1011; rnd = 4'd7; req = 1'b1;
        cyc();
        req = 1'b0;
        repeat (10) cyc();
        chk("abort_busy_scan", 32'(busy), 32'd1);
        rst = 1'b0;
        cyc();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_we",   32'(spawn_we), 32'd0);
        chk("abort_idx",  32'(spawn_idx), 32'd0);
        rst = 1'b1;
        we_seen = 0;
        repeat (24) begin
            cyc();
            if (spawn_we || done) we_seen++;
        end
        chk("abort_no_write", 32'(we_seen), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
